// File: rtl/hms_bcd_converter.sv
// hms_bcd_converter: captures a packed hh:mm:ss word on start and converts
// each binary field to two BCD digits using a 7-step shift-add-3 engine.
// Also maintains a colon-blink flag driven by the half-second pulse.
module hms_bcd_converter #(
  parameter int HRS_MAX = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] hms_time,
  input  logic        half_sec_pulse,
  output logic [23:0] bcd_time,
  output logic        done,
  output logic        busy,
  output logic        valid,
  output logic        hrs_ovf,
  output logic        colon
);

  localparam logic [6:0] HRS_LIMIT = 7'(HRS_MAX);
  localparam logic [2:0] LAST_ITER = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] iter_cnt;
  logic [6:0] hh_bin, mm_bin, ss_bin;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       ovf_cap;
  logic       unused_hms_msb;

  // Bit 19 of the time word carries no information.
  assign unused_hms_msb = hms_time[19];

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
  function automatic logic [7:0] add3(input logic [7:0] bcd);
    logic [3:0] hi, lo;
    hi = bcd[7:4];
    lo = bcd[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  // One double-dabble iteration: adjust, then shift {bcd, bin} left by one.
  function automatic logic [14:0] dabble(input logic [7:0] bcd, input logic [6:0] bin);
    logic [7:0] adj;
    adj = add3(bcd);
    return {adj[6:0], bin, 1'b0};
  endfunction

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: start only matters in IDLE, so it is never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (iter_cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter: cleared on capture, advanced once per SHIFT cycle.
  always_ff @(posedge clock) begin
    if (reset)                      iter_cnt <= 3'd0;
    else if (state == IDLE && start) iter_cnt <= 3'd0;
    else if (state == SHIFT)         iter_cnt <= iter_cnt + 3'd1;
  end

  // Conversion datapath: capture with hour saturation, then iterate all
  // three fields in lockstep. Scratch contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      if (hms_time[18:12] > HRS_LIMIT) begin
        hh_bin  <= HRS_LIMIT;
        ovf_cap <= 1'b1;
      end else begin
        hh_bin  <= hms_time[18:12];
        ovf_cap <= 1'b0;
      end
      mm_bin <= {1'b0, hms_time[11:6]};
      ss_bin <= {1'b0, hms_time[5:0]};
      hh_bcd <= 8'd0;
      mm_bcd <= 8'd0;
      ss_bcd <= 8'd0;
    end else if (state == SHIFT) begin
      {hh_bcd, hh_bin} <= dabble(hh_bcd, hh_bin);
      {mm_bcd, mm_bin} <= dabble(mm_bcd, mm_bin);
      {ss_bcd, ss_bin} <= dabble(ss_bcd, ss_bin);
    end
  end

  // Result registers: updated only from DONE so partial values never show.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcd_time <= 24'h000000;
      hrs_ovf  <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        bcd_time <= {hh_bcd, mm_bcd, ss_bcd};
        hrs_ovf  <= ovf_cap;
        valid    <= 1'b1;
      end
    end
  end

  // Colon blink flag, independent of the conversion FSM.
  always_ff @(posedge clock) begin
    if (reset)               colon <= 1'b1;
    else if (half_sec_pulse) colon <= ~colon;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hms_bcd_converter.sv
// Testbench for hms_bcd_converter: scenario tasks against a decimal-arithmetic
// reference model of the hh:mm:ss to BCD conversion.
module tb_hms_bcd_converter;

  localparam int HRS_MAX = 99;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] hms_time = 20'h0;
  logic        half_sec_pulse = 1'b0;
  logic [23:0] bcd_time;
  logic        done, busy, valid, hrs_ovf, colon;

  int checks = 0;
  int errors = 0;

  hms_bcd_converter #(.HRS_MAX(HRS_MAX)) dut (
    .clock(clock), .reset(reset), .start(start), .hms_time(hms_time),
    .half_sec_pulse(half_sec_pulse), .bcd_time(bcd_time), .done(done),
    .busy(busy), .valid(valid), .hrs_ovf(hrs_ovf), .colon(colon)
  );

  always #5 clock = ~clock;

  // Reference: saturate hours, then split each field into tens and units.
  function automatic logic [23:0] ref_bcd(input logic [19:0] t, output logic ovf);
    int h, m, s;
    h = int'(t[18:12]);
    m = int'(t[11:6]);
    s = int'(t[5:0]);
    ovf = (h > HRS_MAX);
    if (ovf) h = HRS_MAX;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Drive a one-cycle start; returns just after the sampling edge k.
  task automatic pulse_start(input logic [19:0] t);
    @(negedge clock);
    hms_time = t;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges after k at which done was seen, 0 if never.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checks++; if (bcd_time !== 24'h000000) begin errors++; $display("FAIL reset_bcd: got %h want 000000", bcd_time); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (colon !== 1'b1) begin errors++; $display("FAIL reset_colon: got %b want 1", colon); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hrs_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", hrs_ovf); end
  endtask

  task automatic test_basic;
    pulse_start(20'h0C8B8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_k: got %b want 1", busy); end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL basic_busy_k+%0d: busy %b done %b want busy 1 done 0", i, busy, done);
      end
    end
    @(negedge clock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_k+8: got %b want 1", done); end
    checks++; if (bcd_time !== 24'h123456) begin errors++; $display("FAIL basic_bcd: got %h want 123456", bcd_time); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid); end
    @(negedge clock);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_k+9: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_boundary;
    logic [19:0] vec [6] = '{20'h00000, 20'h63EFB, 20'h0003F, 20'h78000, 20'h05000, 20'h7FFFF};
    logic [23:0] exp;
    logic        eovf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      exp = ref_bcd(vec[i], eovf);
      pulse_start(vec[i]);
      wait_done(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL bound_lat[%0d]: got %0d want 8", i, lat); end
      checks++; if (bcd_time !== exp || hrs_ovf !== eovf) begin
        errors++; $display("FAIL bound[%0d] in %h: got %h ovf %b want %h ovf %b", i, vec[i], bcd_time, hrs_ovf, exp, eovf);
      end
    end
  endtask

  task automatic test_random;
    logic [19:0] t;
    logic [23:0] exp;
    logic        eovf;
    int          lat;
    for (int i = 0; i < 25; i++) begin
      t = {1'b0, 19'($urandom)};
      exp = ref_bcd(t, eovf);
      pulse_start(t);
      wait_done(lat);
      checks++; if (lat != 8 || bcd_time !== exp || hrs_ovf !== eovf) begin
        errors++; $display("FAIL rand[%0d] in %h: lat %0d got %h ovf %b want lat 8 %h ovf %b", i, t, lat, bcd_time, hrs_ovf, exp, eovf);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] a = 20'h0A1C5;
    logic [19:0] b = 20'h3B7A2;
    logic [19:0] c = 20'h17D9E;
    logic [23:0] exp;
    logic        eovf;
    int          lat;
    pulse_start(a);
    repeat (3) @(negedge clock);
    hms_time = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    lat = 0;
    for (int n = 5; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin lat = n; break; end
    end
    exp = ref_bcd(a, eovf);
    checks++; if (lat != 8 || bcd_time !== exp) begin
      errors++; $display("FAIL ignore_start: lat %0d got %h want lat 8 %h", lat, bcd_time, exp);
    end
    hms_time = c;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_k+9_busy: got %b want 1", busy); end
    wait_done(lat);
    exp = ref_bcd(c, eovf);
    checks++; if (lat != 8 || bcd_time !== exp) begin
      errors++; $display("FAIL accept_k+9: lat %0d got %h want lat 8 %h", lat, bcd_time, exp);
    end
  endtask

  task automatic test_reset_mid_and_colon;
    logic [19:0] d = 20'h2D2CF;
    logic [23:0] exp;
    logic        eovf;
    int          lat;
    int          seen;
    pulse_start(20'h63EFB);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || hrs_ovf !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl: busy %b done %b valid %b ovf %b want 0 0 0 0", busy, done, valid, hrs_ovf);
    end
    checks++; if (bcd_time !== 24'h000000 || colon !== 1'b1) begin
      errors++; $display("FAIL midreset_data: bcd %h colon %b want 000000 1", bcd_time, colon);
    end
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_abort: activity cycles %0d want 0", seen); end
    half_sec_pulse = 1'b1;
    @(negedge clock);
    half_sec_pulse = 1'b0;
    checks++; if (colon !== 1'b0) begin errors++; $display("FAIL colon_1: got %b want 0", colon); end
    @(negedge clock);
    hms_time       = d;
    start          = 1'b1;
    half_sec_pulse = 1'b1;
    @(negedge clock);
    start          = 1'b0;
    half_sec_pulse = 1'b0;
    checks++; if (colon !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL colon_2_with_start: colon %b busy %b want 1 1", colon, busy);
    end
    wait_done(lat);
    exp = ref_bcd(d, eovf);
    checks++; if (lat != 8 || bcd_time !== exp) begin
      errors++; $display("FAIL coincident_conv: lat %0d got %h want lat 8 %h", lat, bcd_time, exp);
    end
    half_sec_pulse = 1'b1;
    @(negedge clock);
    half_sec_pulse = 1'b0;
    checks++; if (colon !== 1'b0) begin errors++; $display("FAIL colon_3: got %b want 0", colon); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_random;
    test_back_to_back;
    test_reset_mid_and_colon;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
